// File: rtl/mpa_seq.sv
// Multi-precision byte-serial add/sub sequencer driving an external 8-bit adder.
// Optional zero-result flag enabled by defining MPA_SEQ_ZERO_FLAG_EN.
module mpa_seq #(
    parameter int LEN_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [LEN_W-1:0] len_m1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a_byte,
    input  logic [7:0]       b_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic [7:0]       as_a,
    output logic [7:0]       as_b,
    output logic             as_cin,
    output logic             as_sub,
    output logic             as_take_carry,
    input  logic [7:0]       as_sum,
    input  logic             as_cout,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // a producer holds its data stable while valid=1 and ready=0.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             op_sub_q, op_sub_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_valid_q, out_valid_d;
    logic             carry_q, carry_d;
    logic             accept;
    logic             first_byte;

    assign first_byte = (cnt_q == '0);
    assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept     = (state_q == RUN) && in_valid && in_ready;

    // Only the first byte uses the unit's native subtract; later bytes
    // propagate the carry with a pre-inverted B operand.
    always_comb begin
        as_a          = a_byte;
        as_b          = b_byte;
        as_sub        = op_sub_q;
        as_take_carry = 1'b0;
        as_cin        = 1'b0;
        if (!first_byte) begin
            as_b          = op_sub_q ? ~b_byte : b_byte;
            as_sub        = 1'b0;
            as_take_carry = 1'b1;
            as_cin        = carry_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_sub_d    = op_sub_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        carry_d     = carry_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_sub_d = op_sub;
                    len_d    = len_m1;
                    cnt_d    = '0;
                    carry_d  = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (accept && (cnt_q == len_q)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            out_byte_d  = as_sum;
            out_valid_d = 1'b1;
            carry_d     = as_cout;
            cnt_d       = cnt_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_sub_q    <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_sub_q    <= op_sub_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
        end
    end

`ifdef MPA_SEQ_ZERO_FLAG_EN
    logic zero_q, zero_d;

    // Starts optimistic and is knocked down by any non-zero result byte.
    always_comb begin
        zero_d = zero_q;
        if ((state_q == IDLE) && start) begin
            zero_d = 1'b1;
        end else if (accept) begin
            zero_d = zero_q && (as_sum == 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`else
    assign zero = 1'b0;
`endif

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign carry     = carry_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule
